// File: rtl/multi_clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider: output modes,
// reset divisor and a constant-safe ceil(log2) helper.
package multi_clock_divider_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_DIV_VAL = 50000000;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, active/shadow divisor pair with pending flag,
// and the registered clk_out/tick outputs.
module multi_clock_divider_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int unsigned W           = 32,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         mode_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_value_i,
    output logic         clk_out_o,
    output logic         tick_o,
    output logic         pend_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] active_q, active_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         pend_q, pend_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    mode_e        mode_q, mode_d;

    logic [W-1:0] eff;
    logic         wrap;
    logic         pulse;
    logic         toggle_base;

    // Divisors 0 and 1 both run at full rate so a channel can never stall.
    assign eff   = (active_q <= W'(1)) ? W'(1) : active_q;
    assign wrap  = en_i && (cnt_q == (eff - W'(1)));
    assign pulse = (mode_e'(mode_i) == MODE_PULSE);
    // Leaving pulse mode restarts the toggle output from low.
    assign toggle_base = (mode_q == MODE_PULSE) ? 1'b0 : clk_out_q;

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        mode_d    = mode_e'(mode_i);

        if (sync_i) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            active_d  = ld_i ? ld_value_i : shadow_q;
            shadow_d  = ld_i ? ld_value_i : shadow_q;
            pend_d    = 1'b0;
        end else if (!en_i) begin
            // No running period to protect: a pending divisor goes live now.
            if (pend_q) begin
                active_d = shadow_q;
            end
            if (ld_i) begin
                shadow_d = ld_value_i;
            end
            pend_d = ld_i;
            if (pulse) begin
                clk_out_d = 1'b0;
            end
        end else if (wrap) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = pulse ? 1'b1 : ~toggle_base;
            if (ld_i) begin
                active_d = ld_value_i;
                shadow_d = ld_value_i;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
        end else begin
            cnt_d     = cnt_q + W'(1);
            clk_out_d = pulse ? 1'b0 : toggle_base;
            if (ld_i) begin
                shadow_d = ld_value_i;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            active_q  <= W'(DEFAULT_DIV);
            shadow_q  <= W'(DEFAULT_DIV);
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            mode_q    <= MODE_TOGGLE;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            mode_q    <= mode_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: load decode and sync fan-out
// around NCH independent divider channels.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned W           = 32,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL,
    localparam int unsigned CHW        = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic [NCH-1:0] mode,
    input  logic           div_load,
    input  logic [CHW-1:0] div_ch,
    input  logic [W-1:0]   div_value,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    logic           ch_valid;
    logic [NCH-1:0] ld_we;

    // Out-of-range channel selects are dropped without touching any state.
    assign ch_valid = (32'(div_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ld_we[i] = div_load && ch_valid && (div_ch == CHW'(i));

        multi_clock_divider_channel #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en[i]),
            .sync_i     (sync),
            .mode_i     (mode[i]),
            .ld_i       (ld_we[i]),
            .ld_value_i (div_value),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i]),
            .pend_o     (pend[i])
        );
    end

endmodule
